// File: rtl/compare_stream.sv
`default_nettype none
// ============================================================================
//  Module      : compare_stream
//  Description : Counts low/high samples in groups of up to NUM samples
//                (a group closes early on i_in_last). It then presents the two
//                counts, a majority flag and an early-close flag on a
//                valid/ready result port.
//  Revision    : 1.0  initial release
// ============================================================================
module compare_stream #(
  parameter int WIDTH  = 4,
  parameter int NUM    = 3,
  parameter int THRESH = 8,
  parameter bit TIE_RC = 1'b1,
  localparam int CW    = $clog2(NUM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_rc,
  output logic [CW-1:0]    o_out_nl,
  output logic [CW-1:0]    o_out_ng,
  output logic             o_out_early
);

  // The threshold is one bit wider than the data so that 2^WIDTH is
  // representable and classifies every sample as low.
  localparam logic [WIDTH:0]  c_THRESH = (WIDTH + 1)'(THRESH);
  localparam logic [CW-1:0]   c_NUM    = CW'(NUM);
  localparam logic [CW-1:0]   c_ONE    = CW'(1);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_nl;
  logic [CW-1:0]   r_ng;

  logic [CW-1:0]   r_out_nl;
  logic [CW-1:0]   r_out_ng;
  logic            r_out_rc;
  logic            r_out_early;

  logic            w_is_low;
  logic            w_accept;
  logic            w_handshake;
  logic [CW-1:0]   w_cnt_inc;
  logic [CW-1:0]   w_nl_inc;
  logic [CW-1:0]   w_ng_inc;
  logic            w_full;
  logic            w_close;
  logic            w_rc;

  // Unsigned classification at WIDTH+1 bits.
  assign w_is_low    = ({1'b0, i_in_data} < c_THRESH);

  // Handshakes are decoded from state only.
  assign w_accept    = i_in_valid  && (r_state == ST_ACC);
  assign w_handshake = i_out_ready && (r_state == ST_OUT);

  // Counter values including the sample being accepted this cycle. Samples
  // are only accepted in ACC, where the count is below NUM, so these cannot
  // exceed NUM or wrap.
  assign w_cnt_inc   = r_cnt + c_ONE;
  assign w_nl_inc    = r_nl + CW'(w_is_low);
  assign w_ng_inc    = r_ng + CW'(!w_is_low);

  // A group closes when it fills or when the accepted sample is marked last.
  // Filling takes precedence for the early flag when both coincide.
  assign w_full      = (w_cnt_inc == c_NUM);
  assign w_close     = w_accept && (w_full || i_in_last);

  // Fewer lows than highs gives 1, more lows gives 0, a tie gives TIE_RC.
  always_comb begin
    w_rc = TIE_RC;
    if (w_nl_inc < w_ng_inc) begin
      w_rc = 1'b1;
    end else if (w_nl_inc > w_ng_inc) begin
      w_rc = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: ACC -> OUT on a closing accept, OUT -> ACC on the result handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC: if (w_close)     w_state_nxt = ST_OUT;
      ST_OUT: if (w_handshake) w_state_nxt = ST_ACC;
      default:                 w_state_nxt = ST_ACC;
    endcase
  end

  // Group counters: step on every accept, clear once the result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_nl  <= '0;
      r_ng  <= '0;
    end else if (w_handshake) begin
      r_cnt <= '0;
      r_nl  <= '0;
      r_ng  <= '0;
    end else if (w_accept) begin
      r_cnt <= w_cnt_inc;
      r_nl  <= w_nl_inc;
      r_ng  <= w_ng_inc;
    end
  end

  // Result registers: captured on the closing accept and held until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_nl    <= '0;
      r_out_ng    <= '0;
      r_out_rc    <= 1'b0;
      r_out_early <= 1'b0;
    end else if (w_close) begin
      r_out_nl    <= w_nl_inc;
      r_out_ng    <= w_ng_inc;
      r_out_rc    <= w_rc;
      r_out_early <= !w_full;
    end
  end

  assign o_in_ready  = (r_state == ST_ACC);
  assign o_out_valid = (r_state == ST_OUT);
  assign o_out_nl    = r_out_nl;
  assign o_out_ng    = r_out_ng;
  assign o_out_rc    = r_out_rc;
  assign o_out_early = r_out_early;

endmodule
`default_nettype wire

// File: tb/tb_compare_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compare_stream
//  Description : Self-checking bench for compare_stream. It uses a table of
//                groups plus hand-written corner sequences. Expected results
//                are queued as each group is driven and compared on the
//                result handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_compare_stream;

  typedef struct {
    int n;
    int d[3];
    bit last;
    int gap;
    int nl;
    int ng;
    int rc;
    int early;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       i_valid;
  logic       i_last;
  logic [3:0] i_data;
  logic       i_out_ready;

  // Index 0: defaults, 1: TIE_RC=0, 2: THRESH=0, 3: THRESH=16.
  logic [3:0]      rdy;
  logic [3:0]      vld;
  logic [3:0]      rc;
  logic [3:0]      early;
  logic [3:0][1:0] nl;
  logic [3:0][1:0] ng;

  logic       w_valid;
  logic       w_last;
  logic [7:0] w_data;
  logic       w_oready;
  logic       w_rdy;
  logic       w_vld;
  logic       w_rc;
  logic       w_early;
  logic [2:0] w_nl;
  logic [2:0] w_ng;

  int checks = 0;
  int errors = 0;
  vec_t q[$];
  vec_t tbl[9];
  vec_t hv;

  compare_stream u_dut (
    .clk(clk), .rst(rst), .i_in_valid(i_valid), .o_in_ready(rdy[0]),
    .i_in_data(i_data), .i_in_last(i_last), .o_out_valid(vld[0]),
    .i_out_ready(i_out_ready), .o_out_rc(rc[0]), .o_out_nl(nl[0]),
    .o_out_ng(ng[0]), .o_out_early(early[0])
  );

  compare_stream #(.TIE_RC(1'b0)) u_tie0 (
    .clk(clk), .rst(rst), .i_in_valid(i_valid), .o_in_ready(rdy[1]),
    .i_in_data(i_data), .i_in_last(i_last), .o_out_valid(vld[1]),
    .i_out_ready(i_out_ready), .o_out_rc(rc[1]), .o_out_nl(nl[1]),
    .o_out_ng(ng[1]), .o_out_early(early[1])
  );

  compare_stream #(.THRESH(0)) u_th0 (
    .clk(clk), .rst(rst), .i_in_valid(i_valid), .o_in_ready(rdy[2]),
    .i_in_data(i_data), .i_in_last(i_last), .o_out_valid(vld[2]),
    .i_out_ready(i_out_ready), .o_out_rc(rc[2]), .o_out_nl(nl[2]),
    .o_out_ng(ng[2]), .o_out_early(early[2])
  );

  compare_stream #(.THRESH(16)) u_th16 (
    .clk(clk), .rst(rst), .i_in_valid(i_valid), .o_in_ready(rdy[3]),
    .i_in_data(i_data), .i_in_last(i_last), .o_out_valid(vld[3]),
    .i_out_ready(i_out_ready), .o_out_rc(rc[3]), .o_out_nl(nl[3]),
    .o_out_ng(ng[3]), .o_out_early(early[3])
  );

  compare_stream #(.WIDTH(8), .NUM(5), .THRESH(100)) u_w8 (
    .clk(clk), .rst(rst), .i_in_valid(w_valid), .o_in_ready(w_rdy),
    .i_in_data(w_data), .i_in_last(w_last), .o_out_valid(w_vld),
    .i_out_ready(w_oready), .o_out_rc(w_rc), .o_out_nl(w_nl),
    .o_out_ng(w_ng), .o_out_early(w_early)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Present one sample and hold it until it is accepted (bounded wait).
  task automatic send(input logic [3:0] d, input logic l);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    while (!acc && n < 50) begin
      acc = rdy[0];
      @(posedge clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic send8(input logic [7:0] d, input logic l);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    w_valid = 1'b1;
    w_data  = d;
    w_last  = l;
    while (!acc && n < 50) begin
      acc = w_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    if (!acc) chk("accept8_timeout", 0, 1);
  endtask

  task automatic send_group(input vec_t v, input bit push);
    if (push) q.push_back(v);
    for (int i = 0; i < v.n; i++) begin
      if (i > 0) begin
        repeat (v.gap) begin
          @(posedge clk);
          #1;
        end
      end
      send(4'(v.d[i]), (i == v.n - 1) && v.last);
      if (i < v.n - 1) chk("no_early_valid", vld[0], 0);
    end
    chk("latency1", vld[0], 1);
  endtask

  // Scoreboard: compare every instance sharing the 4-bit stream on each result handshake.
  always @(negedge clk) begin
    if (!rst && vld[0] && i_out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        vec_t e;
        int   n;
        e = q.pop_front();
        n = e.nl + e.ng;
        chk("nl", nl[0], e.nl);
        chk("ng", ng[0], e.ng);
        chk("rc", rc[0], e.rc);
        chk("early", early[0], e.early);
        chk("sum", nl[0] + ng[0], n);
        chk("tie0_valid", vld[1], 1);
        chk("tie0_rc", rc[1], (e.nl == e.ng) ? 0 : e.rc);
        chk("th0_nl", nl[2], 0);
        chk("th0_ng", ng[2], n);
        chk("th0_rc", rc[2], 1);
        chk("th0_early", early[2], e.early);
        chk("th16_nl", nl[3], n);
        chk("th16_ng", ng[3], 0);
        chk("th16_rc", rc[3], 0);
      end
    end
  end

  initial begin
    tbl[0] = '{3, '{0, 2, 7},  1'b0, 0, 3, 0, 0, 0};
    tbl[1] = '{3, '{5, 8, 15}, 1'b0, 2, 1, 2, 1, 0};
    tbl[2] = '{2, '{7, 8, 0},  1'b1, 0, 1, 1, 1, 1};
    tbl[3] = '{1, '{15, 0, 0}, 1'b1, 0, 0, 1, 1, 1};
    tbl[4] = '{1, '{3, 0, 0},  1'b1, 1, 1, 0, 0, 1};
    tbl[5] = '{3, '{9, 3, 12}, 1'b1, 0, 1, 2, 1, 0};
    tbl[6] = '{3, '{8, 9, 10}, 1'b0, 1, 0, 3, 1, 0};
    tbl[7] = '{3, '{6, 12, 4}, 1'b0, 0, 2, 1, 0, 0};
    tbl[8] = '{1, '{0, 0, 0},  1'b1, 0, 1, 0, 0, 1};

    rst = 1'b1;
    i_valid = 1'b0; i_last = 1'b0; i_data = '0; i_out_ready = 1'b1;
    w_valid = 1'b0; w_last = 1'b0; w_data = '0; w_oready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    chk("rst_valid", vld[0], 0);
    chk("rst_ready", rdy[0], 1);
    chk("rst_nl", nl[0], 0);
    chk("rst_ng", ng[0], 0);
    chk("rst_rc", rc[0], 0);
    chk("rst_early", early[0], 0);
    chk("rst_w8_valid", w_vld, 0);
    chk("rst_w8_ready", w_rdy, 1);

    // Table-driven groups.
    for (int k = 0; k < 9; k++) send_group(tbl[k], 1'b1);

    // Back-pressure: result held while a new sample waits.
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    hv = '{3, '{1, 2, 3}, 1'b0, 0, 3, 0, 0, 0};
    send_group(hv, 1'b1);
    i_valid = 1'b1;
    i_data  = 4'd9;
    repeat (3) begin
      chk("hold_ready", rdy[0], 0);
      chk("hold_valid", vld[0], 1);
      chk("hold_nl", nl[0], 3);
      chk("hold_ng", ng[0], 0);
      chk("hold_rc", rc[0], 0);
      @(posedge clk);
      #1;
    end
    i_out_ready = 1'b1;
    hv = '{3, '{9, 10, 11}, 1'b0, 0, 0, 3, 1, 0};
    q.push_back(hv);
    send(4'd9, 1'b0);
    send(4'd10, 1'b0);
    send(4'd11, 1'b0);
    chk("held_sample_counted", vld[0], 1);

    // Reset mid-group discards the partial group.
    @(posedge clk);
    #1;
    send(4'd7, 1'b0);
    send(4'd7, 1'b0);
    chk("pair_no_result", vld[0], 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", vld[0], 0);
    chk("midrst_ready", rdy[0], 1);
    hv = '{3, '{9, 10, 11}, 1'b0, 0, 0, 3, 1, 0};
    send_group(hv, 1'b1);

    // Reset while a result is pending drops it with no handshake.
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    hv = '{2, '{1, 14, 0}, 1'b1, 0, 1, 1, 1, 1};
    send_group(hv, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_out_ready = 1'b1;
    chk("outrst_valid", vld[0], 0);
    chk("outrst_nl", nl[0], 0);
    chk("outrst_early", early[0], 0);
    send_group(tbl[7], 1'b1);

    // Wider instance: 8-bit samples, groups of five, threshold 100.
    send8(8'd99, 1'b0);
    send8(8'd100, 1'b0);
    send8(8'd255, 1'b0);
    send8(8'd0, 1'b0);
    chk("w8_no_early_valid", w_vld, 0);
    send8(8'd100, 1'b0);
    chk("w8_valid", w_vld, 1);
    chk("w8_nl", w_nl, 2);
    chk("w8_ng", w_ng, 3);
    chk("w8_rc", w_rc, 1);
    chk("w8_early", w_early, 0);
    chk("w8_sum", w_nl + w_ng, 5);
    send8(8'd50, 1'b0);
    send8(8'd200, 1'b1);
    chk("w8b_valid", w_vld, 1);
    chk("w8b_nl", w_nl, 1);
    chk("w8b_ng", w_ng, 1);
    chk("w8b_rc", w_rc, 1);
    chk("w8b_early", w_early, 1);
    chk("w8b_sum", w_nl + w_ng, 2);

    // Drain the scoreboard (bounded).
    for (int t = 0; t < 20 && q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
